// File: rtl/trig_lut_arbiter.sv
// Four-requester arbiter sharing one synchronous sin/cos ROM; grant-to-result latency is two cycles.
// Define TRIG_ARB_FIXED_PRIO_EN for fixed priority (req[0] highest); round robin otherwise.
module trig_lut_arbiter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  req,
    input  logic [23:0] angle_in,
    output logic [3:0]  gnt,
    output logic [5:0]  rom_addr,
    output logic        rom_en,
    input  logic [7:0]  rom_sin,
    input  logic [7:0]  rom_cos,
    output logic [7:0]  sin_out,
    output logic [7:0]  cos_out,
    output logic [3:0]  valid,
    output logic        err
);

    localparam logic [5:0] ANGLE_MAX = 6'd44;

    logic        win_found;
    logic [1:0]  win_idx;
    logic [5:0]  ang_sel;
    logic        ang_oor;

    logic [3:0]  gnt_d,      gnt_q;
    logic [5:0]  rom_addr_d, rom_addr_q;
    logic        rom_en_d,   rom_en_q;
    logic        err_d,      err_q;
    logic [3:0]  own_p1_q;
    logic [3:0]  valid_q;
    logic [7:0]  sin_q, cos_q;

`ifdef TRIG_ARB_FIXED_PRIO_EN
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = 2'(i);
            end
        end
    end
`else
    logic [1:0] last_q;
    logic [1:0] last_d;

    // Descending scan so the candidate closest to last_q+1 is written last and wins.
    always_comb begin
        logic [1:0] cand;
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        last_d = win_found ? win_idx : last_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) last_q <= 2'd3;
        else       last_q <= last_d;
    end
`endif

    always_comb begin
        case (win_idx)
            2'd0:    ang_sel = angle_in[5:0];
            2'd1:    ang_sel = angle_in[11:6];
            2'd2:    ang_sel = angle_in[17:12];
            default: ang_sel = angle_in[23:18];
        endcase
        ang_oor    = ang_sel > ANGLE_MAX;
        gnt_d      = win_found ? (4'b0001 << win_idx) : 4'b0000;
        rom_en_d   = win_found;
        err_d      = win_found & ang_oor;
        rom_addr_d = rom_addr_q;
        if (win_found) rom_addr_d = ang_oor ? 6'd0 : ang_sel;
    end

    // Stage E1: grant and ROM request; E2: ROM access in flight; E3: capture result.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            gnt_q      <= 4'b0000;
            rom_addr_q <= 6'd0;
            rom_en_q   <= 1'b0;
            err_q      <= 1'b0;
            own_p1_q   <= 4'b0000;
            valid_q    <= 4'b0000;
            sin_q      <= 8'd0;
            cos_q      <= 8'd0;
        end else begin
            gnt_q      <= gnt_d;
            rom_addr_q <= rom_addr_d;
            rom_en_q   <= rom_en_d;
            err_q      <= err_d;
            own_p1_q   <= gnt_q;
            valid_q    <= own_p1_q;
            if (|own_p1_q) begin
                sin_q <= rom_sin;
                cos_q <= rom_cos;
            end
        end
    end

    assign gnt      = gnt_q;
    assign rom_addr = rom_addr_q;
    assign rom_en   = rom_en_q;
    assign err      = err_q;
    assign valid    = valid_q;
    assign sin_out  = sin_q;
    assign cos_out  = cos_q;

endmodule
